intr_ack_handler: RTL
=====================

// Module: intr_ack_handler
// PURPOSE
//  Processor-side partner of the polling interrupt controller, directly downstream of it.
//  - Consumes the controller's interrupt request and answers with active-low acknowledge pulses.
//  - Captures the source ID from the shared 8-bit bus, hands it to the core as an ISR request,
//    then returns the done code {DONE_CODE, id} on the bus so the controller resumes polling.
// PARAMETERS
//  REQ_CODE      5'b01011  upper-5-bit tag the controller puts on the bus with the source ID
//  DONE_CODE     5'b10100  upper-5-bit tag this block drives back when the ISR completes
//  TIMEOUT_CYC   255       max cycles to wait in WAIT_ID or BUS_WAIT before going to ERROR
//  CNT_W         8         width of the timeout counter; TIMEOUT_CYC < 2**CNT_W
// PORTS
//  clk          in     1  clock, all state changes on rising edge
//  reset        in     1  asynchronous, active-high
//  intr_req     in     1  interrupt request from the controller (its intr_out)
//  intr_ack_n   out    1  acknowledge to the controller (its intr_in); idle high, 1-cycle low pulses
//  intr_bus     inout  8  shared bidirectional bus; driven only while bus_oe=1
//  ctrl_bus_oe  in     1  controller's bus-drive indication (its bus_oe)
//  bus_oe       out    1  this block is driving intr_bus
//  isr_start    out    1  1-cycle pulse: ISR request to the core, isr_id valid
//  isr_id       out    3  captured interrupt source ID; held until the next capture
//  isr_busy     out    1  high from isr_start until isr_done is accepted
//  isr_done     in     1  core finished the ISR; sampled only in ISR_WAIT
//  err          out    1  sticky protocol error flag
//  err_clr      in     1  clears err and returns the block to IDLE
//  serviced_cnt out   16  count of completed interrupts; wraps 16'hFFFF->0
// BEHAVIOUR
//  Reset values (asynchronous):
//  - state=IDLE, intr_ack_n=1, bus_oe=0 (bus Z immediately), isr_start=0, isr_id=0,
//    isr_busy=0, err=0, serviced_cnt=0, timeout counter=0.
//  Output timing: all outputs are registered. Each value below takes effect on the edge
//  that enters the named state.
//  State machine:
//  - IDLE: intr_ack_n=1. On intr_req=1 -> ACK_REQ.
//  - ACK_REQ: intr_ack_n=0 for exactly one cycle, then WAIT_ID. Timeout counter cleared.
//  - WAIT_ID: when ctrl_bus_oe=1 and intr_bus[7:3]==REQ_CODE:
//      capture isr_id=intr_bus[2:0], then -> ACK_ID.
//    When ctrl_bus_oe=1 and intr_bus[7:3]!=REQ_CODE -> ERROR.
//    When the counter reaches TIMEOUT_CYC -> ERROR.
//  - ACK_ID: intr_ack_n=0 for one cycle, isr_start=1 for one cycle, isr_busy=1 -> ISR_WAIT.
//  - ISR_WAIT: wait for isr_done=1. isr_done is accepted from the cycle after isr_start.
//    On acceptance: isr_busy=0, counter cleared -> BUS_WAIT.
//  - BUS_WAIT: bus contention guard. Wait until ctrl_bus_oe=0, then -> DRIVE_SETUP.
//    Counter reaches TIMEOUT_CYC -> ERROR.
//  - DRIVE_SETUP: bus_oe=1, intr_bus={DONE_CODE,isr_id}, intr_ack_n=1. One cycle of data setup.
//  - DONE_ACK: bus still driven, intr_ack_n=0 for one cycle, serviced_cnt+1.
//    Next edge: bus_oe=0, intr_ack_n=1 -> IDLE.
//  - ERROR: intr_ack_n=1, bus_oe=0, err=1. Stays until err_clr=1, then err=0 -> IDLE.
//    The controller itself needs a system reset to recover.
//  Boundary rules:
//  - Acknowledge pulses are never longer than one cycle. A 2-cycle pulse would skip a controller state.
//  - At least one cycle with intr_ack_n=1 between any two pulses.
//  - isr_done outside ISR_WAIT is ignored.
//  - intr_req outside IDLE is ignored. intr_req still high on return to IDLE starts a new sequence.
//  - bus_oe and ctrl_bus_oe are never both 1. If ctrl_bus_oe rises while bus_oe=1 -> ERROR,
//    and the bus is released on that edge.
//  - err_clr outside ERROR has no effect.
//  - Reset mid-operation: immediate return to reset values, including releasing the bus.
// TESTING
//  1. Full handshake: intr_req=1; controller drives 8'h5D (01011_101) with ctrl_bus_oe=1
//     -> ack pulse, isr_start with isr_id=5; isr_done
//     -> bus carries 8'hA5 while intr_ack_n=0 for 1 cycle; serviced_cnt=1.
//  2. Bad tag: in WAIT_ID drive 8'hFF with ctrl_bus_oe=1
//     -> err=1, bus_oe=0, intr_ack_n=1; err_clr -> err=0, IDLE.
//  3. Timeout: no ctrl_bus_oe after ACK_REQ
//     -> err=1 exactly TIMEOUT_CYC cycles after entering WAIT_ID.
//  4. Contention: hold ctrl_bus_oe=1 when isr_done arrives
//     -> bus_oe stays 0; release after 3 cycles -> DRIVE_SETUP on the next edge.
//  5. Early isr_done in IDLE/WAIT_ID -> ignored. Back-to-back requests on IDs 0..7
//     -> serviced_cnt=8, each ack pulse exactly 1 cycle wide.
//  6. Reset asserted in DONE_ACK -> intr_bus Z, intr_ack_n=1, serviced_cnt=0 asynchronously.

Source files
------------

// File: rtl/intr_ack_handler.sv
// rtl/intr_ack_handler.sv - processor-side interrupt acknowledge handler
// Acknowledges controller requests, captures the source ID and returns the done code on the shared bus.
module intr_ack_handler #(
  parameter logic [4:0] REQ_CODE    = 5'b01011,
  parameter logic [4:0] DONE_CODE   = 5'b10100,
  parameter int         TIMEOUT_CYC = 255,
  parameter int         CNT_W       = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        intr_req,
  output logic        intr_ack_n,
  inout  wire  [7:0]  intr_bus,
  input  logic        ctrl_bus_oe,
  output logic        bus_oe,
  output logic        isr_start,
  output logic [2:0]  isr_id,
  output logic        isr_busy,
  input  logic        isr_done,
  output logic        err,
  input  logic        err_clr,
  output logic [15:0] serviced_cnt
);

  typedef enum logic [3:0] {
    IDLE, ACK_REQ, WAIT_ID, ACK_ID, ISR_WAIT, BUS_WAIT, DRIVE_SETUP, DONE_ACK, ERROR
  } state_t;

  state_t           state, next_state;
  logic [CNT_W-1:0] tmo_cnt;
  logic             timeout;
  logic             ack_n_nxt, bus_oe_nxt, start_nxt, busy_nxt, err_nxt;
  logic [2:0]       id_nxt;
  logic [15:0]      cnt_nxt;

  assign timeout  = (tmo_cnt == CNT_W'(TIMEOUT_CYC - 1));
  assign intr_bus = bus_oe ? {DONE_CODE, isr_id} : 8'bz;

  always_comb begin
    next_state = state;
    case (state)
      IDLE:        if (intr_req) next_state = ACK_REQ;
      ACK_REQ:     next_state = WAIT_ID;
      WAIT_ID: begin
        if (ctrl_bus_oe)
          next_state = (intr_bus[7:3] == REQ_CODE) ? ACK_ID : ERROR;
        else if (timeout)
          next_state = ERROR;
      end
      ACK_ID:      next_state = ISR_WAIT;
      ISR_WAIT:    if (isr_done) next_state = BUS_WAIT;
      BUS_WAIT: begin
        if (!ctrl_bus_oe)
          next_state = DRIVE_SETUP;
        else if (timeout)
          next_state = ERROR;
      end
      // The controller must never drive while we own the bus.
      DRIVE_SETUP: next_state = ctrl_bus_oe ? ERROR : DONE_ACK;
      DONE_ACK:    next_state = ctrl_bus_oe ? ERROR : IDLE;
      ERROR:       if (err_clr) next_state = IDLE;
      default:     next_state = IDLE;
    endcase

    // Outputs are registered from the state being entered.
    ack_n_nxt  = !(next_state inside {ACK_REQ, ACK_ID, DONE_ACK});
    bus_oe_nxt = next_state inside {DRIVE_SETUP, DONE_ACK};
    start_nxt  = (next_state == ACK_ID);
    busy_nxt   = next_state inside {ACK_ID, ISR_WAIT};
    err_nxt    = (next_state == ERROR);
    id_nxt     = isr_id;
    cnt_nxt    = serviced_cnt;
    if (state == WAIT_ID && next_state == ACK_ID)
      id_nxt = intr_bus[2:0];
    if (state == DRIVE_SETUP && next_state == DONE_ACK)
      cnt_nxt = serviced_cnt + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      tmo_cnt      <= '0;
      intr_ack_n   <= 1'b1;
      bus_oe       <= 1'b0;
      isr_start    <= 1'b0;
      isr_id       <= 3'd0;
      isr_busy     <= 1'b0;
      err          <= 1'b0;
      serviced_cnt <= 16'd0;
    end else begin
      state        <= next_state;
      // Cleared on every state change, so it counts residency in the current state.
      tmo_cnt      <= (next_state == state) ? tmo_cnt + 1'b1 : '0;
      intr_ack_n   <= ack_n_nxt;
      bus_oe       <= bus_oe_nxt;
      isr_start    <= start_nxt;
      isr_id       <= id_nxt;
      isr_busy     <= busy_nxt;
      err          <= err_nxt;
      serviced_cnt <= cnt_nxt;
    end
  end

endmodule
